// File: rtl/alu_result_fifo.sv
// Capture FIFO for ALU results with valid/ready handshake, drop counting and flag checks.
// Optional ovf_cnt output is enabled by defining ALU_FIFO_OVF_STATS_EN.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [7:0]               in_y,
  input  logic [4:0]               in_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_op,
  output logic [7:0]               out_y,
  output logic [4:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     flag_err
`ifdef ALU_FIFO_OVF_STATS_EN
  ,
  output logic [CNT_W-1:0]         ovf_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [14:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          cmp_ok;
  logic [14:0]   head;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign cmp_ok = (in_flags[2:0] == 3'b100) ||
                  (in_flags[2:0] == 3'b010) ||
                  (in_flags[2:0] == 3'b001);

  // Mask the head so unwritten storage never reaches the consumer
  assign head = empty ? '0 : mem[rd_ptr];
  assign {out_op, out_flags, out_y} = head;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_op, in_flags, in_y};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      flag_err <= 1'b0;
    end else begin
      if (in_valid && full && drop_cnt != '1)
        drop_cnt <= drop_cnt + 1'b1;
      if (push && !cmp_ok)
        flag_err <= 1'b1;
    end
  end

`ifdef ALU_FIFO_OVF_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (push && in_flags[3] && ovf_cnt != '1) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end
`endif

endmodule
